dm_hart_runctrl: RTL and testbench
==================================

Name: dm_hart_runctrl

Overview:
Per-hart run-control sequencer for the RISC-V debug module (spec 0.13.2).
- Converts dmcontrol halt/resume/hartreset requests into handshakes with one core: debug request, resume request and hart reset.
- Tracks hart state and produces the dmstatus per-hart bits: halted, running, unavail, resumeack, havereset.
- The DM instantiates one copy per hart and ORs/ANDs the status bits across selected harts.

Parameters:
TIMEOUT_W  8  width of handshake timeout counter; timeout fires after 2^TIMEOUT_W-1 cycles in a request state

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
dmactive_i  in  1  dmcontrol.dmactive; low = synchronous clear of requests
haltreq_i  in  1  level halt request for this hart
resumereq_i  in  1  single-cycle resume request pulse
hartreset_i  in  1  level hart reset request
ackhavereset_i  in  1  single-cycle pulse clearing havereset
hart_halted_i  in  1  core reports halted in debug mode
hart_running_i  in  1  core reports executing normally
debug_req_o  out  1  halt request to core
resume_req_o  out  1  resume request to core
hart_reset_o  out  1  reset to core
halted_o  out  1  dmstatus halted bit
running_o  out  1  dmstatus running bit
unavail_o  out  1  dmstatus unavail bit
resumeack_o  out  1  dmstatus resumeack bit
havereset_o  out  1  dmstatus havereset bit
err_o  out  1  sticky handshake-timeout flag

Behaviour:
- Reset (async, rst_i=1): state=UNAVAIL; all outputs 0 except unavail_o=1 and havereset_o=1.
- All outputs are registered.
  - Status bits decode the state: halted_o for HALTED or RESUME_REQ; running_o for RUNNING or HALT_REQ; unavail_o for UNAVAIL or RESET.
  - debug_req_o=1 only in HALT_REQ; resume_req_o=1 only in RESUME_REQ; hart_reset_o=1 only in RESET.
- Latency: an input sampled at edge N affects state and outputs at N+1.
- FSM states: UNAVAIL, RUNNING, HALT_REQ, HALTED, RESUME_REQ, RESET.
- Transition priority, highest first:
  - rst_i.
  - !dmactive_i: go to UNAVAIL; err_o cleared; havereset_o and resumeack_o retained.
  - hartreset_i: go to RESET from any state.
  - State-specific rules below.
- UNAVAIL:
  - hart_halted_i -> HALTED.
  - Else hart_running_i -> RUNNING.
  - Else stay.
- RUNNING:
  - hart_halted_i (unsolicited ebreak) -> HALTED.
  - Else haltreq_i -> HALT_REQ.
  - Neither running nor halted -> UNAVAIL.
- HALT_REQ:
  - hart_halted_i -> HALTED.
  - haltreq_i dropped -> RUNNING.
  - Timeout -> RUNNING and err_o set.
- HALTED:
  - resumereq_i with !haltreq_i -> RESUME_REQ; resumeack_o cleared the same edge.
  - resumereq_i with haltreq_i high is ignored.
- RESUME_REQ:
  - hart_running_i && !hart_halted_i -> RUNNING; resumeack_o set.
  - Timeout -> HALTED and err_o set.
- RESET:
  - Held while hartreset_i=1.
  - On release -> UNAVAIL.
  - havereset_o set on entry.
- Timeout counter:
  - Cleared on entry to HALT_REQ or RESUME_REQ.
  - Increments each cycle in those states and saturates.
  - Timeout fires when count == 2^TIMEOUT_W-1; the transition happens on that edge.
- havereset_o:
  - Set on entry to RESET.
  - Cleared by ackhavereset_i.
  - Set wins over a simultaneous clear.
- resumereq_i arriving outside HALTED is dropped; it is not queued.
- err_o is cleared only by !dmactive_i or rst_i.
- rst_i mid-handshake aborts immediately: debug_req_o/resume_req_o drop asynchronously.

Test Plan:
- Reset then hart_running_i=1 -> unavail_o 1 then 0 one cycle later; running_o=1; havereset_o=1; ackhavereset_i pulse -> havereset_o=0 next cycle.
- RUNNING, haltreq_i=1 at edge N -> debug_req_o=1 at N+1; hart_halted_i at N+3 -> halted_o=1 and debug_req_o=0 at N+4; running_o=0.
- HALTED, resumereq_i pulse -> resume_req_o=1 and resumeack_o=0 next cycle; hart_running_i=1, hart_halted_i=0 -> running_o=1, resumeack_o=1, resume_req_o=0.
- TIMEOUT_W=3, haltreq_i held, core never halts -> debug_req_o high 7 cycles, then RUNNING with err_o=1; dmactive_i=0 -> err_o=0, unavail_o=1.
- hartreset_i=1 during RESUME_REQ -> hart_reset_o=1 and resume_req_o=0 next cycle; release -> UNAVAIL; ackhavereset_i on RESET-entry edge -> havereset_o stays 1.
- HALTED with haltreq_i=1 and resumereq_i pulse -> stays HALTED, resume_req_o=0; unsolicited hart_halted_i in RUNNING -> halted_o=1 with debug_req_o never asserted.

Source files
------------

// File: rtl/dm_hart_runctrl.sv
// Per-hart run-control sequencer for the RISC-V debug module.
// Turns halt/resume/hartreset requests into core handshakes and produces dmstatus per-hart bits.
module dm_hart_runctrl #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dmactive_i,
    input  logic haltreq_i,
    input  logic resumereq_i,
    input  logic hartreset_i,
    input  logic ackhavereset_i,
    input  logic hart_halted_i,
    input  logic hart_running_i,
    output logic debug_req_o,
    output logic resume_req_o,
    output logic hart_reset_o,
    output logic halted_o,
    output logic running_o,
    output logic unavail_o,
    output logic resumeack_o,
    output logic havereset_o,
    output logic err_o
);

    localparam logic [2:0] ST_UNAVAIL    = 3'd0;
    localparam logic [2:0] ST_RUNNING    = 3'd1;
    localparam logic [2:0] ST_HALT_REQ   = 3'd2;
    localparam logic [2:0] ST_HALTED     = 3'd3;
    localparam logic [2:0] ST_RESUME_REQ = 3'd4;
    localparam logic [2:0] ST_RESET      = 3'd5;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = {TIMEOUT_W{1'b1}};
    // One below the limit: the edge that would make the count reach the limit is the timeout edge.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_MAX - TIMEOUT_W'(1'b1);

    logic [2:0]           state_r;
    logic [TIMEOUT_W-1:0] cnt_r;
    logic [2:0]           next_state_s;
    logic                 timeout_s;
    logic                 err_set_s;
    logic                 ack_set_s;
    logic                 ack_clr_s;
    logic                 enter_req_s;
    logic                 in_req_s;
    logic                 enter_reset_s;

    // Next-state selection with dmactive and hartreset overriding the per-state rules.
    always_comb begin
        next_state_s = state_r;
        err_set_s    = 1'b0;
        ack_set_s    = 1'b0;
        ack_clr_s    = 1'b0;
        timeout_s    = (cnt_r == CNT_LAST);
        if (!dmactive_i) begin
            next_state_s = ST_UNAVAIL;
        end else if (hartreset_i) begin
            next_state_s = ST_RESET;
        end else begin
            case (state_r)
                ST_UNAVAIL: begin
                    if (hart_halted_i) begin
                        next_state_s = ST_HALTED;
                    end else if (hart_running_i) begin
                        next_state_s = ST_RUNNING;
                    end else begin
                        next_state_s = ST_UNAVAIL;
                    end
                end
                ST_RUNNING: begin
                    if (hart_halted_i) begin
                        next_state_s = ST_HALTED;
                    end else if (haltreq_i) begin
                        next_state_s = ST_HALT_REQ;
                    end else if (!hart_running_i) begin
                        next_state_s = ST_UNAVAIL;
                    end else begin
                        next_state_s = ST_RUNNING;
                    end
                end
                ST_HALT_REQ: begin
                    if (hart_halted_i) begin
                        next_state_s = ST_HALTED;
                    end else if (!haltreq_i) begin
                        next_state_s = ST_RUNNING;
                    end else if (timeout_s) begin
                        next_state_s = ST_RUNNING;
                        err_set_s    = 1'b1;
                    end else begin
                        next_state_s = ST_HALT_REQ;
                    end
                end
                ST_HALTED: begin
                    if (resumereq_i && !haltreq_i) begin
                        next_state_s = ST_RESUME_REQ;
                        ack_clr_s    = 1'b1;
                    end else begin
                        next_state_s = ST_HALTED;
                    end
                end
                ST_RESUME_REQ: begin
                    if (hart_running_i && !hart_halted_i) begin
                        next_state_s = ST_RUNNING;
                        ack_set_s    = 1'b1;
                    end else if (timeout_s) begin
                        next_state_s = ST_HALTED;
                        err_set_s    = 1'b1;
                    end else begin
                        next_state_s = ST_RESUME_REQ;
                    end
                end
                ST_RESET: begin
                    next_state_s = ST_UNAVAIL;
                end
                default: begin
                    next_state_s = ST_UNAVAIL;
                end
            endcase
        end
    end

    // Entry/occupancy qualifiers for the timeout counter and havereset.
    always_comb begin
        in_req_s      = (state_r == ST_HALT_REQ) || (state_r == ST_RESUME_REQ);
        enter_req_s   = ((next_state_s == ST_HALT_REQ) || (next_state_s == ST_RESUME_REQ))
                        && (next_state_s != state_r);
        enter_reset_s = (next_state_s == ST_RESET) && (state_r != ST_RESET);
    end

    // State, counter, sticky flags and output registers; outputs decode the next state so they track state_r.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_UNAVAIL;
            cnt_r        <= '0;
            err_o        <= 1'b0;
            havereset_o  <= 1'b1;
            resumeack_o  <= 1'b0;
            debug_req_o  <= 1'b0;
            resume_req_o <= 1'b0;
            hart_reset_o <= 1'b0;
            halted_o     <= 1'b0;
            running_o    <= 1'b0;
            unavail_o    <= 1'b1;
        end else begin
            state_r <= next_state_s;

            if (enter_req_s) begin
                cnt_r <= '0;
            end else if (in_req_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + TIMEOUT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (!dmactive_i) begin
                err_o <= 1'b0;
            end else if (err_set_s) begin
                err_o <= 1'b1;
            end else begin
                err_o <= err_o;
            end

            if (enter_reset_s) begin
                havereset_o <= 1'b1;
            end else if (ackhavereset_i) begin
                havereset_o <= 1'b0;
            end else begin
                havereset_o <= havereset_o;
            end

            if (ack_set_s) begin
                resumeack_o <= 1'b1;
            end else if (ack_clr_s) begin
                resumeack_o <= 1'b0;
            end else begin
                resumeack_o <= resumeack_o;
            end

            debug_req_o  <= (next_state_s == ST_HALT_REQ);
            resume_req_o <= (next_state_s == ST_RESUME_REQ);
            hart_reset_o <= (next_state_s == ST_RESET);
            halted_o     <= (next_state_s == ST_HALTED)  || (next_state_s == ST_RESUME_REQ);
            running_o    <= (next_state_s == ST_RUNNING) || (next_state_s == ST_HALT_REQ);
            unavail_o    <= (next_state_s == ST_UNAVAIL) || (next_state_s == ST_RESET);
        end
    end

endmodule

// File: tb/tb_dm_hart_runctrl.sv
// Directed bench for dm_hart_runctrl with a behavioural reference model and per-cycle output comparison.
module tb_dm_hart_runctrl;

    localparam int LIMIT = 7;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic dmactive_i = 1'b1;
    logic haltreq_i = 1'b0;
    logic resumereq_i = 1'b0;
    logic hartreset_i = 1'b0;
    logic ackhavereset_i = 1'b0;
    logic hart_halted_i = 1'b0;
    logic hart_running_i = 1'b0;
    logic debug_req_o, resume_req_o, hart_reset_o, halted_o, running_o;
    logic unavail_o, resumeack_o, havereset_o, err_o;

    int passed = 0;
    int total = 0;
    bit cmp_en = 1'b0;

    dm_hart_runctrl #(.TIMEOUT_W(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .dmactive_i(dmactive_i), .haltreq_i(haltreq_i),
        .resumereq_i(resumereq_i), .hartreset_i(hartreset_i), .ackhavereset_i(ackhavereset_i),
        .hart_halted_i(hart_halted_i), .hart_running_i(hart_running_i),
        .debug_req_o(debug_req_o), .resume_req_o(resume_req_o), .hart_reset_o(hart_reset_o),
        .halted_o(halted_o), .running_o(running_o), .unavail_o(unavail_o),
        .resumeack_o(resumeack_o), .havereset_o(havereset_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: hart mode, cycles spent waiting in a request, and the sticky flags.
    typedef enum {M_UNAV, M_RUN, M_HREQ, M_HALTED, M_RREQ, M_RST} mode_t;
    mode_t m_mode;
    int    m_wait;
    bit    m_err, m_hr, m_ack;

    function automatic void model_step(input mode_t md, input int wt, input bit er, input bit hr,
                                       input bit ak, output mode_t nmd, output int nwt,
                                       output bit ner, output bit nhr, output bit nak);
        int elapsed;
        elapsed = wt + 1;
        nmd = md; ner = er; nhr = hr; nak = ak;
        if (!dmactive_i) begin
            nmd = M_UNAV;
            ner = 1'b0;
        end else if (hartreset_i) begin
            nmd = M_RST;
        end else if (md == M_UNAV) begin
            if (hart_halted_i) nmd = M_HALTED;
            else if (hart_running_i) nmd = M_RUN;
        end else if (md == M_RUN) begin
            if (hart_halted_i) nmd = M_HALTED;
            else if (haltreq_i) nmd = M_HREQ;
            else if (!hart_running_i) nmd = M_UNAV;
        end else if (md == M_HREQ) begin
            if (hart_halted_i) nmd = M_HALTED;
            else if (!haltreq_i) nmd = M_RUN;
            else if (elapsed == LIMIT) begin nmd = M_RUN; ner = 1'b1; end
        end else if (md == M_HALTED) begin
            if (resumereq_i && !haltreq_i) begin nmd = M_RREQ; nak = 1'b0; end
        end else if (md == M_RREQ) begin
            if (hart_running_i && !hart_halted_i) begin nmd = M_RUN; nak = 1'b1; end
            else if (elapsed == LIMIT) begin nmd = M_HALTED; ner = 1'b1; end
        end else begin
            nmd = M_UNAV;
        end
        if (nmd == M_RST && md != M_RST) nhr = 1'b1;
        else if (ackhavereset_i) nhr = 1'b0;
        nwt = (nmd != md) ? 0 : elapsed;
    endfunction

    // Advance the model on each clock edge, resetting with the DUT.
    always @(posedge clk or posedge rst_i) begin
        mode_t nmd; int nwt; bit ner, nhr, nak;
        if (rst_i) begin
            m_mode <= M_UNAV; m_wait <= 0; m_err <= 1'b0; m_hr <= 1'b1; m_ack <= 1'b0;
        end else begin
            model_step(m_mode, m_wait, m_err, m_hr, m_ack, nmd, nwt, ner, nhr, nak);
            m_mode <= nmd; m_wait <= nwt; m_err <= ner; m_hr <= nhr; m_ack <= nak;
        end
    end

    function automatic logic [8:0] model_outs();
        return {m_mode == M_HREQ, m_mode == M_RREQ, m_mode == M_RST,
                m_mode == M_HALTED || m_mode == M_RREQ, m_mode == M_RUN || m_mode == M_HREQ,
                m_mode == M_UNAV || m_mode == M_RST, m_ack, m_hr, m_err};
    endfunction

    wire [8:0] dut_outs = {debug_req_o, resume_req_o, hart_reset_o, halted_o, running_o,
                           unavail_o, resumeack_o, havereset_o, err_o};

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) chk("model_outs", {23'd0, dut_outs}, {23'd0, model_outs()});
    end

    initial begin
        int n;
        bit ok;
        #1 rst_i = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("reset_outs", {23'd0, dut_outs}, 32'h0000_000A);
        rst_i = 1'b0;
        cmp_en = 1'b1;

        // Core comes up running.
        hart_running_i = 1'b1;
        @(negedge clk);
        chk("run_unavail", unavail_o, 0);
        chk("run_running", running_o, 1);
        chk("run_havereset", havereset_o, 1);
        ackhavereset_i = 1'b1;
        @(negedge clk);
        ackhavereset_i = 1'b0;
        chk("ack_havereset", havereset_o, 0);

        // Requested halt.
        haltreq_i = 1'b1;
        @(negedge clk);
        chk("halt_debug_req", debug_req_o, 1);
        @(negedge clk); @(negedge clk);
        hart_halted_i = 1'b1; hart_running_i = 1'b0;
        @(negedge clk);
        chk("halt_halted", halted_o, 1);
        chk("halt_debug_drop", debug_req_o, 0);
        chk("halt_running", running_o, 0);

        // Resume.
        haltreq_i = 1'b0; resumereq_i = 1'b1;
        @(negedge clk);
        resumereq_i = 1'b0;
        chk("resume_req", resume_req_o, 1);
        chk("resume_ack_clr", resumeack_o, 0);
        hart_running_i = 1'b1; hart_halted_i = 1'b0;
        @(negedge clk);
        chk("resume_running", running_o, 1);
        chk("resume_ack_set", resumeack_o, 1);
        chk("resume_req_drop", resume_req_o, 0);

        // Halt timeout: core never halts.
        haltreq_i = 1'b1;
        n = 0; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (debug_req_o) n++;
            else if (n > 0) begin ok = 1'b1; break; end
        end
        haltreq_i = 1'b0;
        chk("halt_timeout_seen", ok, 1);
        chk("halt_timeout_len", n, 7);
        chk("halt_timeout_err", err_o, 1);
        chk("halt_timeout_running", running_o, 1);
        dmactive_i = 1'b0;
        @(negedge clk);
        dmactive_i = 1'b1;
        chk("dmactive_err_clr", err_o, 0);
        chk("dmactive_unavail", unavail_o, 1);
        @(negedge clk);
        chk("back_running", running_o, 1);

        // Unsolicited halt from RUNNING.
        hart_halted_i = 1'b1; hart_running_i = 1'b0;
        @(negedge clk);
        chk("ebreak_halted", halted_o, 1);
        chk("ebreak_no_dbgreq", debug_req_o, 0);

        // Resume ignored while haltreq is high.
        haltreq_i = 1'b1; resumereq_i = 1'b1;
        @(negedge clk);
        resumereq_i = 1'b0;
        chk("resume_ignored", resume_req_o, 0);
        chk("resume_ignored_halted", halted_o, 1);
        haltreq_i = 1'b0; resumereq_i = 1'b1;
        @(negedge clk);
        resumereq_i = 1'b0;
        chk("resume_req2", resume_req_o, 1);

        // Hart reset during RESUME_REQ, ack on the entry edge.
        hartreset_i = 1'b1; ackhavereset_i = 1'b1;
        @(negedge clk);
        ackhavereset_i = 1'b0;
        chk("hreset_out", hart_reset_o, 1);
        chk("hreset_resume_drop", resume_req_o, 0);
        chk("hreset_havereset", havereset_o, 1);
        @(negedge clk);
        chk("hreset_held", hart_reset_o, 1);
        hart_halted_i = 1'b0; hartreset_i = 1'b0;
        @(negedge clk);
        chk("hreset_release_unavail", unavail_o, 1);
        chk("hreset_release_out", hart_reset_o, 0);

        // Resume timeout: core stays halted.
        hart_halted_i = 1'b1;
        @(negedge clk);
        resumereq_i = 1'b1;
        @(negedge clk);
        resumereq_i = 1'b0;
        n = 0; ok = 1'b0;
        if (resume_req_o) n = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resume_req_o) n++;
            else begin ok = 1'b1; break; end
        end
        chk("resume_timeout_seen", ok, 1);
        chk("resume_timeout_len", n, 7);
        chk("resume_timeout_err", err_o, 1);
        chk("resume_timeout_halted", halted_o, 1);

        // Asynchronous reset mid-handshake.
        resumereq_i = 1'b1;
        @(negedge clk);
        resumereq_i = 1'b0;
        chk("pre_rst_resume_req", resume_req_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_resume_drop", resume_req_o, 0);
        chk("async_rst_unavail", unavail_o, 1);
        chk("async_rst_err", err_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk); @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
